op_out_arb: RTL

- Round-robin arbiter that shares the single op_out result bus (4-bit data plus data_en strobe) between NUM_REQ logic-op result sources.
- Each source offers results over a valid/ready handshake. The block grants one beat per cycle and registers it onto the bus.
- A source may hold the bus for at most MAX_BURST consecutive beats before the grant rotates.
- Sits between the op units and the op_out port; downstream backpressure arrives on out_stall.

---
 rtl/op_out_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/op_out_arb.sv
// Round-robin arbiter sharing the op_out result bus between NUM_REQ op units.
// A source keeps priority for up to MAX_BURST consecutive beats before rotation.
module op_out_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        out_stall,
    output logic [DATA_W-1:0]           data,
    output logic                        data_en,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic [3:0]                  burst_cnt
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_owner;
    logic [3:0]        r_burst;
    logic [DATA_W-1:0] r_data;
    logic              r_en;
    logic [PW-1:0]     r_gid;

    logic [PW-1:0]     w_ptr_nxt;
    logic [PW-1:0]     w_owner_nxt;
    logic [3:0]        w_burst_nxt;
    logic [PW-1:0]     w_owner_inc;
    logic [PW-1:0]     w_prio;
    logic [PW-1:0]     w_sel;
    logic [PW-1:0]     w_idx;
    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_ready;
    logic              w_load;
    logic              w_any;
    logic              w_others;
    logic              w_keep;
    logic              w_xfer;

    function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] i);
        if (i == PW'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + PW'(1);
    endfunction

    assign w_load      = !r_en || !out_stall;
    assign w_owner_inc = inc_idx(r_owner);

    always_comb begin
        w_mask          = req_valid;
        w_mask[r_owner] = 1'b0;
        w_others        = |w_mask;
    end

    // Owner keeps priority until its burst quota is used up and someone else waits.
    always_comb begin
        w_keep = (r_state == S_BURST) && req_valid[r_owner]
                 && ((r_burst < MAXB) || !w_others);
        w_prio = r_ptr;
        if (r_state == S_BURST) begin
            w_prio = w_keep ? r_owner : w_owner_inc;
        end
    end

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PW'((int'(w_prio) + k) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_xfer  = rst_n && w_load && w_any;
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign req_ready = w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst;
        if (w_load) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        w_state_nxt = S_BURST;
                        w_owner_nxt = w_sel;
                        w_burst_nxt = 4'd1;
                    end
                end
                S_BURST: begin
                    if (!w_any) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_owner_inc;
                        w_burst_nxt = 4'd0;
                    end else if (w_sel == r_owner) begin
                        if (r_burst < MAXB) begin
                            w_burst_nxt = r_burst + 4'd1;
                        end
                    end else begin
                        w_ptr_nxt   = w_owner_inc;
                        w_owner_nxt = w_sel;
                        w_burst_nxt = 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    // Bus registers only move when the downstream can take a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_en   <= 1'b0;
            r_gid  <= '0;
        end else if (w_load) begin
            r_en <= w_xfer;
            if (w_xfer) begin
                r_data <= req_data[w_sel*DATA_W +: DATA_W];
                r_gid  <= w_sel;
            end
        end
    end

    assign data      = r_data;
    assign data_en   = r_en;
    assign grant_id  = r_gid;
    assign burst_cnt = r_burst;

endmodule
